key_debounce: RTL
=================

// Module: key_debounce
// PURPOSE
//  Input-side counterpart of the LED output path: samples the raw active-low KEY pushbuttons.
//  Synchronises each key to CLOCK_50, debounces it and presents a clean pressed level.
//  Also produces one-cycle press/release strobes for LED/counter logic downstream.
//  Sits between board KEY pins and any consumer of user button events.
// PARAMETERS
//  NUM_KEYS        2       number of independent key channels
//  DEBOUNCE_COUNT  500000  consecutive stable cycles required to accept a change (10 ms @ 50 MHz); must be >= 1
//  REPEAT_DELAY    25000000  cycles held after key_press before first key_repeat (used only with KEY_REPEAT_EN)
//  REPEAT_PERIOD   5000000   cycles between subsequent key_repeat strobes (used only with KEY_REPEAT_EN)
// PORTS
//  CLOCK_50     in   1         single system clock, all logic on posedge
//  rst          in   1         synchronous, active-high reset
//  KEY          in   NUM_KEYS  raw asynchronous buttons, 0 = pressed
//  key_level    out  NUM_KEYS  debounced state, 1 = pressed
//  key_press    out  NUM_KEYS  1-cycle strobe on accepted press
//  key_release  out  NUM_KEYS  1-cycle strobe on accepted release
//  key_repeat   out  NUM_KEYS  1-cycle auto-repeat strobe while held (constant 0 without KEY_REPEAT_EN)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all outputs 0; sync flops load 1 (released); counters 0; FSM RELEASED.
//  - Sync: 2-flop synchroniser per key, inverted to active-high; 2-cycle latency.
//  - Per-key FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
//    RELEASED: synced=1 -> PRESS_WAIT, cnt<=1.
//    PRESS_WAIT: synced=0 -> RELEASED, cnt<=0 (glitch rejected).
//      synced=1 and cnt==DEBOUNCE_COUNT -> PRESSED, key_level<=1, key_press pulses for 1 cycle.
//      Otherwise cnt++.
//    PRESSED: synced=0 -> RELEASE_WAIT, cnt<=1.
//    RELEASE_WAIT: symmetric to PRESS_WAIT; synced=1 -> PRESSED.
//      Completion -> RELEASED, key_level<=0, key_release pulses.
//  - Latency: raw edge to strobe is 2 + DEBOUNCE_COUNT cycles. Pulses shorter than DEBOUNCE_COUNT synced cycles are ignored.
//  - cnt width CNT_W = $clog2(DEBOUNCE_COUNT+1); never wraps (state exits at DEBOUNCE_COUNT).
//  - Channels fully independent; simultaneous presses give same-cycle strobes.
//  - key_press and key_release are never high together on one key.
//  - Reset mid-operation aborts any WAIT state. A key held through reset is reported as a press 2+DEBOUNCE_COUNT cycles after rst falls.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//    - In PRESSED, a repeat counter starts on the key_press cycle.
//    - key_repeat pulses REPEAT_DELAY cycles later, then every REPEAT_PERIOD cycles while still PRESSED.
//    - Counter clears on leaving PRESSED or on rst.
//  Not defined: no repeat counter synthesised; key_repeat tied to '0.
// STRUCTURE
//  key_pkg: typedef enum logic[1:0] key_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}.
//  key_pkg also holds CLK_HZ=50_000_000 and a ms-to-cycles function.
//  Sub-module key_debounce_ch: one channel (sync + FSM + counters), instantiated NUM_KEYS times in a generate loop.
// TESTING  (DEBOUNCE_COUNT=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, NUM_KEYS=2)
//  1 Reset: rst=1 for 2 cycles with KEY=2'b00 -> all outputs 0.
//    After rst=0, key_press=2'b11 exactly 6 cycles later.
//  2 Clean press: KEY[1] 1->0, held 20 cycles -> single key_press[1] pulse 6 cycles after first sampling edge.
//    key_level[1]=1 thereafter; key_press[0] never asserts.
//  3 Glitch: KEY[0] low for 3 cycles then high -> no strobe, key_level[0] stays 0, FSM back to RELEASED.
//  4 Release: from pressed, KEY[1] 0->1 -> key_release[1] pulse 6 cycles later, key_level[1]=0.
//    A 3-cycle bounce high during the release wait restarts the count.
//  5 Reset mid-wait: rst=1 during PRESS_WAIT -> outputs 0 and no strobe during reset.
//    With key still held, the press is reported 6 cycles after rst falls.
//  6 Repeat: hold KEY[0] 30 cycles.
//    With KEY_REPEAT_EN: key_repeat[0] at +8, +12, +16... cycles after key_press[0].
//    Without KEY_REPEAT_EN: key_repeat stays 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and timing helpers for the pushbutton input path.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int CLK_HZ = 50_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, press/release strobes.
// Optional auto-repeat strobe when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_COUNT = 500000,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);

  if (DEBOUNCE_COUNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_debounce_ch: counts must be >= 1");
  end

  logic             meta_q, meta_d;
  logic             sync_q, sync_d;
  logic             synced;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Raw pin is active-low; flops hold the raw level so reset means "released".
  assign meta_d = key_n;
  assign sync_d = meta_q;
  assign synced = ~sync_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      RELEASED: if (synced) begin
        state_d = PRESS_WAIT;
        cnt_d   = CNT_W'(1);
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_COUNT)) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: if (!synced) begin
        state_d = RELEASE_WAIT;
        cnt_d   = CNT_W'(1);
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_COUNT)) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             repeat_q, repeat_d;

  // Counter is 1 on the key_press cycle; first target is the delay, then the period.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    repeat_d    = 1'b0;
    if (state_d == PRESSED && state_q != PRESSED) begin
      rpt_cnt_d   = RPT_W'(1);
      rpt_first_d = 1'b1;
    end else if (state_d == PRESSED && state_q == PRESSED) begin
      if (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD))) begin
        repeat_d    = 1'b1;
        rpt_cnt_d   = RPT_W'(1);
        rpt_first_d = 1'b0;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end else begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      repeat_q    <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_repeat = repeat_q;
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced active-low pushbutton bank with press/release strobes.
// Define KEY_REPEAT_EN to add auto-repeat strobes on held keys.
module key_debounce
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 2,
  parameter int DEBOUNCE_COUNT = ms_to_cycles(10),
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_PERIOD  = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk        (CLOCK_50),
      .rst        (rst),
      .key_n      (KEY[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_repeat (key_repeat[i])
    );
  end

endmodule
